// File: rtl/jk_pkg.sv
// Shared constants for the JK counter register: operating mode encodings.
package jk_pkg;

   localparam logic [1:0] MODE_JK   = 2'b00;
   localparam logic [1:0] MODE_UP   = 2'b01;
   localparam logic [1:0] MODE_DOWN = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/jk_bit_next.sv
// Single-bit JK flip-flop next-state function (purely combinational).
module jk_bit_next (
   input  logic q,
   input  logic j,
   input  logic k,
   output logic q_next
);

   // {j,k}: 00 hold, 01 clear, 10 set, 11 toggle
   always_comb begin
      q_next = q;
      case ({j, k})
         2'b00:   q_next = q;
         2'b01:   q_next = 1'b0;
         2'b10:   q_next = 1'b1;
         default: q_next = ~q;
      endcase
   end

endmodule

// File: rtl/jk_counter_reg.sv
// Multi-mode register: per-bit JK, up/down counter (wrap or saturate) and
// parallel load, with registered terminal-count and changed flags.
module jk_counter_reg
   import jk_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter bit               NEG_EDGE  = 1'b1,
   parameter bit               SATURATE  = 1'b0,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             changed
);

   logic [WIDTH-1:0] q_q, q_d;
   logic             tc_q, tc_d;
   logic             changed_q, changed_d;
   logic [WIDTH-1:0] jk_next;
   logic             all_ones, all_zero;
   logic             clk_act;

   // One register set; the active edge is chosen by steering the clock
   // polarity rather than by duplicating the state logic per edge.
   if (NEG_EDGE) begin : g_neg_edge
      assign clk_act = ~clk;
   end else begin : g_pos_edge
      assign clk_act = clk;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_jk_bit
      jk_bit_next u_jk_bit_next (
         .q      (q_q[i]),
         .j      (j[i]),
         .k      (k[i]),
         .q_next (jk_next[i])
      );
   end

   assign all_ones = (q_q == '1);
   assign all_zero = (q_q == '0);

   // Next-state selection by mode; tc flags a bound hit even when saturated
   always_comb begin
      q_d       = q_q;
      tc_d      = 1'b0;
      changed_d = 1'b0;
      if (en) begin
         case (mode)
            MODE_JK: q_d = jk_next;
            MODE_UP: begin
               tc_d = all_ones;
               if (!(SATURATE && all_ones)) begin
                  q_d = q_q + WIDTH'(1);
               end
            end
            MODE_DOWN: begin
               tc_d = all_zero;
               if (!(SATURATE && all_zero)) begin
                  q_d = q_q - WIDTH'(1);
               end
            end
            default: q_d = d;
         endcase
         changed_d = (q_d != q_q);
      end
   end

   // State register with synchronous active-high reset
   always_ff @(posedge clk_act) begin
      if (reset) begin
         q_q       <= RESET_VAL;
         tc_q      <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         q_q       <= q_d;
         tc_q      <= tc_d;
         changed_q <= changed_d;
      end
   end

   assign q       = q_q;
   assign tc      = tc_q;
   assign changed = changed_q;

endmodule

// File: tb/tb_jk_counter_reg.sv
// Testbench for jk_counter_reg: three configurations driven from shared inputs
// (4-bit wrap/falling, 4-bit saturate/falling, 8-bit RESET_VAL=A5/rising).
module tb_jk_counter_reg;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] j = 8'h00, k = 8'h00, d = 8'h00;

   logic [3:0] q0, q1;
   logic [7:0] q2;
   logic       tc0, tc1, tc2, ch0, ch1, ch2;

   int checks = 0;
   int errors = 0;

   int m0_q = 0, m1_q = 0, m2_q = 0;
   bit m0_tc, m1_tc, m2_tc, m0_ch, m1_ch, m2_ch;

   always #5 clk = ~clk;

   jk_counter_reg #(.WIDTH(4), .NEG_EDGE(1'b1), .SATURATE(1'b0), .RESET_VAL(4'h0)) dut0 (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j[3:0]), .k(k[3:0]), .d(d[3:0]),
      .q(q0), .tc(tc0), .changed(ch0));

   jk_counter_reg #(.WIDTH(4), .NEG_EDGE(1'b1), .SATURATE(1'b1), .RESET_VAL(4'h0)) dut1 (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j[3:0]), .k(k[3:0]), .d(d[3:0]),
      .q(q1), .tc(tc1), .changed(ch1));

   jk_counter_reg #(.WIDTH(8), .NEG_EDGE(1'b0), .SATURATE(1'b0), .RESET_VAL(8'hA5)) dut2 (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k), .d(d),
      .q(q2), .tc(tc2), .changed(ch2));

   // Behavioural reference: integer arithmetic on the current inputs
   function automatic void ref_step(input int w, input bit sat, input int rv,
                                    inout int mq, output bit mtc, output bit mch);
      int maxv, jj, kk, nq;
      maxv = (1 << w) - 1;
      jj = int'(j) & maxv;
      kk = int'(k) & maxv;
      if (reset) begin
         mq = rv; mtc = 1'b0; mch = 1'b0;
         return;
      end
      if (!en) begin
         mtc = 1'b0; mch = 1'b0;
         return;
      end
      case (mode)
         2'd0:    nq = ((jj & ~mq) | (~kk & mq)) & maxv;
         2'd1:    nq = (sat && mq == maxv) ? mq : ((mq + 1) & maxv);
         2'd2:    nq = (sat && mq == 0) ? 0 : ((mq - 1) & maxv);
         default: nq = int'(d) & maxv;
      endcase
      mtc = (mode == 2'd1 && mq == maxv) || (mode == 2'd2 && mq == 0);
      mch = (nq != mq);
      mq  = nq;
   endfunction

   always @(negedge clk) begin
      ref_step(4, 1'b0, 0, m0_q, m0_tc, m0_ch);
      ref_step(4, 1'b1, 0, m1_q, m1_tc, m1_ch);
   end

   always @(posedge clk) ref_step(8, 1'b0, 'hA5, m2_q, m2_tc, m2_ch);

   // Drive one input set and let both a rising and a falling edge pass
   task automatic cyc(input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] jj, input logic [7:0] kk, input logic [7:0] dd);
      reset = r; en = e; mode = m; j = jj; k = kk; d = dd;
      @(posedge clk); #1;
      @(negedge clk); #1;
   endtask

   task automatic test_reset();
      cyc(1'b1, 1'b1, 2'd1, 8'h00, 8'h00, 8'h00);
      cyc(1'b1, 1'b1, 2'd1, 8'h00, 8'h00, 8'h00);
      checks++;
      if ({q0, tc0, ch0} !== {4'h0, 2'b00}) begin
         errors++;
         $display("FAIL reset_dut0: got q=%h tc=%b ch=%b, expected q=0 tc=0 ch=0", q0, tc0, ch0);
      end
      checks++;
      if ({q1, tc1, ch1} !== {4'h0, 2'b00}) begin
         errors++;
         $display("FAIL reset_dut1: got q=%h tc=%b ch=%b, expected q=0 tc=0 ch=0", q1, tc1, ch1);
      end
      checks++;
      if ({q2, tc2, ch2} !== {8'hA5, 2'b00}) begin
         errors++;
         $display("FAIL reset_dut2: got q=%h tc=%b ch=%b, expected q=a5 tc=0 ch=0", q2, tc2, ch2);
      end
   endtask

   task automatic test_jk();
      cyc(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
      // bit3 set, bit2 clear, bit1 toggle, bit0 hold
      cyc(1'b0, 1'b1, 2'd0, 8'h0A, 8'h06, 8'h00);
      checks++;
      if ({q0, tc0, ch0} !== {4'b1010, 2'b01}) begin
         errors++;
         $display("FAIL jk_first: got q=%b tc=%b ch=%b, expected q=1010 tc=0 ch=1", q0, tc0, ch0);
      end
      cyc(1'b0, 1'b1, 2'd0, 8'h0A, 8'h06, 8'h00);
      checks++;
      if ({q0, tc0, ch0} !== {4'b1000, 2'b01}) begin
         errors++;
         $display("FAIL jk_second: got q=%b tc=%b ch=%b, expected q=1000 tc=0 ch=1", q0, tc0, ch0);
      end
   endtask

   task automatic test_count_wrap();
      logic [3:0] eq  [3] = '{4'hF, 4'h0, 4'h1};
      logic       etc [3] = '{1'b0, 1'b1, 1'b0};
      cyc(1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 8'h0E);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 8'h00);
         checks++;
         if ({q0, tc0, ch0} !== {eq[i], etc[i], 1'b1}) begin
            errors++;
            $display("FAIL wrap_up[%0d]: got q=%h tc=%b ch=%b, expected q=%h tc=%b ch=1",
                     i, q0, tc0, ch0, eq[i], etc[i]);
         end
      end
   endtask

   task automatic test_saturate();
      logic etc [3] = '{1'b0, 1'b1, 1'b1};
      logic ech [3] = '{1'b1, 1'b0, 1'b0};
      cyc(1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 8'h01);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 8'h00);
         checks++;
         if ({q1, tc1, ch1} !== {4'h0, etc[i], ech[i]}) begin
            errors++;
            $display("FAIL sat_down[%0d]: got q=%h tc=%b ch=%b, expected q=0 tc=%b ch=%b",
                     i, q1, tc1, ch1, etc[i], ech[i]);
         end
      end
   endtask

   task automatic test_enable_hold();
      cyc(1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 8'h05);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 2'd1, 8'hFF, 8'hFF, 8'hFF);
         checks++;
         if ({q0, tc0, ch0} !== {4'h5, 2'b00}) begin
            errors++;
            $display("FAIL en_hold[%0d]: got q=%h tc=%b ch=%b, expected q=5 tc=0 ch=0",
                     i, q0, tc0, ch0);
         end
      end
   endtask

   task automatic test_reset_mid();
      cyc(1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 8'h10);
      cyc(1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 8'h00);
      checks++;
      if (q2 !== 8'h11) begin
         errors++;
         $display("FAIL mid_count: got q=%h, expected q=11", q2);
      end
      cyc(1'b1, 1'b1, 2'd1, 8'h00, 8'h00, 8'h00);
      checks++;
      if ({q2, tc2, ch2} !== {8'hA5, 2'b00}) begin
         errors++;
         $display("FAIL mid_reset: got q=%h tc=%b ch=%b, expected q=a5 tc=0 ch=0", q2, tc2, ch2);
      end
      cyc(1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 8'h00);
      checks++;
      if ({q2, tc2, ch2} !== {8'hA6, 2'b01}) begin
         errors++;
         $display("FAIL after_reset: got q=%h tc=%b ch=%b, expected q=a6 tc=0 ch=1", q2, tc2, ch2);
      end
   endtask

   task automatic test_edge();
      cyc(1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 8'h00);
      reset = 1'b0; en = 1'b1; mode = 2'd3; d = 8'h3C;
      @(posedge clk); #1;
      checks++;
      if ({q2, q0} !== {8'h3C, 4'h0}) begin
         errors++;
         $display("FAIL edge_rise: got q2=%h q0=%h, expected q2=3c q0=0", q2, q0);
      end
      @(negedge clk); #1;
      checks++;
      if ({q2, q0} !== {8'h3C, 4'hC}) begin
         errors++;
         $display("FAIL edge_fall: got q2=%h q0=%h, expected q2=3c q0=c", q2, q0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 15) == 0);
         en    = ($urandom_range(0, 3) != 0);
         mode  = 2'($urandom_range(0, 3));
         j     = 8'($urandom);
         k     = 8'($urandom);
         d     = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         @(posedge clk); #1;
         checks++;
         if ({q0, tc0, ch0, q1, tc1, ch1, q2, tc2, ch2} !==
             {m0_q[3:0], m0_tc, m0_ch, m1_q[3:0], m1_tc, m1_ch, m2_q[7:0], m2_tc, m2_ch}) begin
            errors++;
            $display("FAIL rand_rise[%0d]: got %h/%b%b %h/%b%b %h/%b%b, expected %h/%b%b %h/%b%b %h/%b%b",
                     i, q0, tc0, ch0, q1, tc1, ch1, q2, tc2, ch2,
                     m0_q[3:0], m0_tc, m0_ch, m1_q[3:0], m1_tc, m1_ch, m2_q[7:0], m2_tc, m2_ch);
         end
         @(negedge clk); #1;
         checks++;
         if ({q0, tc0, ch0, q1, tc1, ch1, q2, tc2, ch2} !==
             {m0_q[3:0], m0_tc, m0_ch, m1_q[3:0], m1_tc, m1_ch, m2_q[7:0], m2_tc, m2_ch}) begin
            errors++;
            $display("FAIL rand_fall[%0d]: got %h/%b%b %h/%b%b %h/%b%b, expected %h/%b%b %h/%b%b %h/%b%b",
                     i, q0, tc0, ch0, q1, tc1, ch1, q2, tc2, ch2,
                     m0_q[3:0], m0_tc, m0_ch, m1_q[3:0], m1_tc, m1_ch, m2_q[7:0], m2_tc, m2_ch);
         end
      end
   endtask

   initial begin
      test_reset();
      test_jk();
      test_count_wrap();
      test_saturate();
      test_enable_hold();
      test_reset_mid();
      test_edge();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
